menu_nav_fsm: RTL and testbench

Parametrised top-level menu navigator. It replaces the fixed four-entry game-select FSM with an N-entry menu that has:
- built-in button edge detection and auto-repeat;
- wrap-around cursor movement;
- a choice of return-to-same-item or return-to-home when a game exits;
- a terminal "exit" entry.

It sits between the debounced button synchronisers and the VGA source mux / background renderer.

---
 rtl/menu_nav_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_menu_nav_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_nav_fsm.sv
`default_nettype none
// ============================================================================
// Module   : menu_nav_fsm
// Purpose  : N-entry menu navigator with button edge detection, auto-repeat,
//            wrap-around cursor, game entry/return and a terminal exit entry.
// Revision : 1.0 - initial release
// ============================================================================
module menu_nav_fsm #(
    parameter int N_ITEMS       = 4,
    parameter int SEL_W         = $clog2(N_ITEMS),
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int RETURN_HOME   = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             button_up,
    input  logic             button_down,
    input  logic             button_right,
    input  logic             game_exit,
    output logic [SEL_W-1:0] vgaMUX,
    output logic [SEL_W-1:0] choice,
    output logic             in_game,
    output logic             halted,
    output logic             enter_pulse,
    output logic             leave_pulse
);

    localparam logic [1:0]       c_MENU = 2'd0;
    localparam logic [1:0]       c_GAME = 2'd1;
    localparam logic [1:0]       c_HALT = 2'd2;
    localparam logic [SEL_W-1:0] c_LAST = SEL_W'(N_ITEMS - 1);

    localparam int c_CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_HOLD_M1 = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int c_REP_M1  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    // Button history, ordered {right, down, up}
    logic [2:0]       btn_d;
    logic [2:0]       btn_q;

    logic [1:0]       state_d;
    logic [1:0]       state_q;
    logic [SEL_W-1:0] cursor_d;
    logic [SEL_W-1:0] cursor_q;

    logic [SEL_W-1:0] vga_d;
    logic [SEL_W-1:0] vga_q;
    logic [SEL_W-1:0] choice_d;
    logic [SEL_W-1:0] choice_q;
    logic             in_game_d;
    logic             in_game_q;
    logic             halted_d;
    logic             halted_q;
    logic             enter_d;
    logic             enter_q;
    logic             leave_d;
    logic             leave_q;

    logic             w_ev_up;
    logic             w_ev_dn;
    logic             w_ev_rt;
    logic             w_ev_ud;
    logic             w_one_held;
    logic             w_rep_tick;
    logic             w_step_up;
    logic             w_step_dn;

    assign btn_d      = {button_right, button_down, button_up};
    assign w_ev_up    = button_up    & ~btn_q[0];
    assign w_ev_dn    = button_down  & ~btn_q[1];
    assign w_ev_rt    = button_right & ~btn_q[2];
    assign w_ev_ud    = w_ev_up | w_ev_dn;
    assign w_one_held = button_up ^ button_down;

    assign w_step_dn  = w_ev_dn | (w_rep_tick & button_down);
    assign w_step_up  = w_ev_up | (w_rep_tick & button_up);

    generate
        if (HOLD_CYCLES > 0) begin : g_repeat
            logic [c_CNT_W-1:0] cnt_d;
            logic [c_CNT_W-1:0] cnt_q;
            logic               phase_d;
            logic               phase_q;
            logic               w_tick;

            // phase_q=0: waiting out the initial hold; phase_q=1: repeating
            always_comb begin
                w_tick  = (state_q == c_MENU) && w_one_held && !w_ev_ud &&
                          (cnt_q == (phase_q ? c_CNT_W'(c_REP_M1) : c_CNT_W'(c_HOLD_M1)));
                cnt_d   = cnt_q;
                phase_d = phase_q;
                if ((state_q != c_MENU) || w_ev_ud || !w_one_held) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end else if (w_tick) begin
                    cnt_d   = '0;
                    phase_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + c_CNT_W'(1);
                end
            end

            always_ff @(posedge sys_clk or posedge sys_rst_n) begin
                if (sys_rst_n) begin
                    cnt_q   <= '0;
                    phase_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    phase_q <= phase_d;
                end
            end

            assign w_rep_tick = w_tick;
        end else begin : g_no_repeat
            assign w_rep_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            btn_q     <= '1;
            state_q   <= c_MENU;
            cursor_q  <= '0;
            vga_q     <= '0;
            choice_q  <= '0;
            in_game_q <= 1'b0;
            halted_q  <= 1'b0;
            enter_q   <= 1'b0;
            leave_q   <= 1'b0;
        end else begin
            btn_q     <= btn_d;
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            vga_q     <= vga_d;
            choice_q  <= choice_d;
            in_game_q <= in_game_d;
            halted_q  <= halted_d;
            enter_q   <= enter_d;
            leave_q   <= leave_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        case (state_q)
            c_MENU: begin
                // Opposing up/down events cancel each other and the confirm
                if (!(w_ev_up && w_ev_dn)) begin
                    if (w_step_dn) begin
                        cursor_d = (cursor_q == c_LAST) ? '0 : cursor_q + SEL_W'(1);
                    end else if (w_step_up) begin
                        cursor_d = (cursor_q == '0) ? c_LAST : cursor_q - SEL_W'(1);
                    end else if (w_ev_rt) begin
                        state_d = (cursor_q == c_LAST) ? c_HALT : c_GAME;
                    end
                end
            end
            c_GAME: begin
                if (game_exit) begin
                    state_d = c_MENU;
                    if (RETURN_HOME != 0) begin
                        cursor_d = '0;
                    end
                end
            end
            c_HALT: begin
                state_d = c_HALT;
            end
            default: begin
                state_d  = c_MENU;
                cursor_d = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they register on the same edge
    always_comb begin
        vga_d     = '0;
        choice_d  = cursor_d;
        in_game_d = 1'b0;
        halted_d  = 1'b0;
        enter_d   = (state_q == c_MENU) && (state_d == c_GAME);
        leave_d   = (state_q == c_GAME) && (state_d == c_MENU);
        case (state_d)
            c_GAME: begin
                vga_d     = cursor_d + SEL_W'(1);
                in_game_d = 1'b1;
            end
            c_HALT: begin
                choice_d = c_LAST;
                halted_d = 1'b1;
            end
            default: begin
                vga_d = '0;
            end
        endcase
    end

    assign vgaMUX      = vga_q;
    assign choice      = choice_q;
    assign in_game     = in_game_q;
    assign halted      = halted_q;
    assign enter_pulse = enter_q;
    assign leave_pulse = leave_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_nav_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_nav_fsm
// Purpose  : Directed and random stimulus for menu_nav_fsm against a
//            cycle-level reference model (RETURN_HOME = 0 and 1 side by side).
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_nav_fsm;

    localparam int N    = 4;
    localparam int H    = 10;
    localparam int R    = 4;
    localparam int SW   = 2;
    localparam int MENU = 0;
    localparam int GAME = 1;
    localparam int HALT = 2;

    logic          clk;
    logic          rst;
    logic          up;
    logic          dn;
    logic          rt;
    logic          gx;
    logic [SW-1:0] vga0;
    logic [SW-1:0] ch0;
    logic [SW-1:0] vga1;
    logic [SW-1:0] ch1;
    logic          ing0, hlt0, ent0, lv0;
    logic          ing1, hlt1, ent1, lv1;

    int       checks;
    int       errors;
    int       mode [2];
    int       cur  [2];
    int       age  [2];
    bit       ent_e[2];
    bit       lv_e [2];
    bit [2:0] prev;
    bit       ru, rd, rr, rx, rrst;

    menu_nav_fsm #(.N_ITEMS(N), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .RETURN_HOME(0)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst), .button_up(up), .button_down(dn),
        .button_right(rt), .game_exit(gx), .vgaMUX(vga0), .choice(ch0),
        .in_game(ing0), .halted(hlt0), .enter_pulse(ent0), .leave_pulse(lv0)
    );

    menu_nav_fsm #(.N_ITEMS(N), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .RETURN_HOME(1)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst), .button_up(up), .button_down(dn),
        .button_right(rt), .game_exit(gx), .vgaMUX(vga1), .choice(ch1),
        .in_game(ing1), .halted(hlt1), .enter_pulse(ent1), .leave_pulse(lv1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mode[d]  = MENU;
            cur[d]   = 0;
            age[d]   = 0;
            ent_e[d] = 1'b0;
            lv_e[d]  = 1'b0;
        end
        prev = 3'b111;
    endtask

    // One clock edge of the menu rules; age counts edges since the hold timer last restarted
    task automatic model_edge(input bit u, input bit d_in, input bit r, input bit x);
        bit eu, ed, er, one, tick;
        eu  = u & ~prev[0];
        ed  = d_in & ~prev[1];
        er  = r & ~prev[2];
        one = u ^ d_in;
        for (int d = 0; d < 2; d++) begin
            ent_e[d] = 1'b0;
            lv_e[d]  = 1'b0;
            tick     = 1'b0;
            if (mode[d] != MENU || eu || ed || !one) begin
                age[d] = 0;
            end else begin
                age[d]++;
                tick = (age[d] >= H) && (((age[d] - H) % R) == 0);
            end
            if (mode[d] == MENU) begin
                if (eu && ed) begin
                    cur[d] = cur[d];
                end else if (ed || (tick && d_in)) begin
                    cur[d] = (cur[d] + 1) % N;
                end else if (eu || (tick && u)) begin
                    cur[d] = (cur[d] + N - 1) % N;
                end else if (er) begin
                    if (cur[d] == N - 1) begin
                        mode[d] = HALT;
                    end else begin
                        mode[d]  = GAME;
                        ent_e[d] = 1'b1;
                    end
                end
            end else if (mode[d] == GAME && x) begin
                mode[d] = MENU;
                lv_e[d] = 1'b1;
                if (d == 1) cur[d] = 0;
            end
        end
        prev = {r, d_in, u};
    endtask

    function automatic int exp_vga(input int d);
        return (mode[d] == GAME) ? cur[d] + 1 : 0;
    endfunction

    function automatic int exp_choice(input int d);
        return (mode[d] == HALT) ? N - 1 : cur[d];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("vga0",    32'(vga0), exp_vga(0));
        chk("choice0", 32'(ch0),  exp_choice(0));
        chk("ingame0", 32'(ing0), (mode[0] == GAME) ? 1 : 0);
        chk("halted0", 32'(hlt0), (mode[0] == HALT) ? 1 : 0);
        chk("enter0",  32'(ent0), 32'(ent_e[0]));
        chk("leave0",  32'(lv0),  32'(lv_e[0]));
        chk("vga1",    32'(vga1), exp_vga(1));
        chk("choice1", 32'(ch1),  exp_choice(1));
        chk("ingame1", 32'(ing1), (mode[1] == GAME) ? 1 : 0);
        chk("halted1", 32'(hlt1), (mode[1] == HALT) ? 1 : 0);
        chk("enter1",  32'(ent1), 32'(ent_e[1]));
        chk("leave1",  32'(lv1),  32'(lv_e[1]));
    endtask

    task automatic step(input bit r_v, input bit u, input bit d_in, input bit rr_v, input bit x);
        @(negedge clk);
        rst = r_v;
        up  = u;
        dn  = d_in;
        rt  = rr_v;
        gx  = x;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(u, d_in, rr_v, x);
        #1 compare_all();
    endtask

    // Called 1 time unit after an edge: asserts reset between edges
    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; up = 1'b0; dn = 1'b0; rt = 1'b0; gx = 1'b0;
        ru = 1'b0; rd = 1'b0; rr = 1'b0; rx = 1'b0; rrst = 1'b0;
        model_reset();

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_choice", 32'(ch0), 0);

        step(0, 1, 0, 0, 0);
        chk("up_wrap", 32'(ch0), 3);
        step(0, 0, 0, 0, 0);
        repeat (5) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("down_wrap", 32'(ch1), 0);

        repeat (2) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 1, 0);
        chk("enter_vga", 32'(vga0), 3);
        chk("enter_pulse", 32'(ent0), 1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("game_ignores_buttons", 32'(ch0), 2);
        step(0, 0, 0, 0, 1);
        chk("return_same", 32'(ch0), 2);
        chk("return_home", 32'(ch1), 0);
        chk("leave_pulse", 32'(lv0), 1);
        step(0, 0, 0, 0, 0);

        async_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (30) step(0, 0, 1, 0, 0);
        chk("auto_repeat", 32'(ch0), 2);
        step(0, 0, 0, 0, 0);

        step(0, 1, 1, 0, 0);
        chk("up_down_cancel", 32'(ch0), 2);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("down_right_move", 32'(ch0), 3);
        chk("down_right_menu", 32'(ing0), 0);
        step(0, 0, 0, 0, 0);

        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        chk("held_through_reset", 32'(ch0), 0);
        step(0, 0, 0, 0, 0);

        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("halt_flag", 32'(hlt0), 1);
        chk("halt_choice", 32'(ch1), 3);
        repeat (20) step(0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                         1'($urandom_range(1)), 1'($urandom_range(1)));
        chk("halt_absorbing", 32'(hlt1), 1);
        async_reset();
        chk("async_reset_halted", 32'(hlt0), 0);
        step(1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) ru = ~ru;
            if ($urandom_range(5) == 0) rd = ~rd;
            if ($urandom_range(9) == 0) rr = ~rr;
            if ($urandom_range(4) == 0) rx = ~rx;
            rrst = ((mode[0] == HALT || mode[1] == HALT) && $urandom_range(7) == 0) ||
                   ($urandom_range(399) == 0);
            step(rrst, ru, rd, rr, rx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
